// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared definitions for the cpu65CE02 bus I/O responder: register
//   offsets inside the 16-byte window, CTRL/STATUS bit positions and the
//   access FSM state encoding.
package cpu_bus_pkg;

    // Register offsets (address[3:0])
    localparam logic [3:0] OFF_PORT_OUT = 4'h0;
    localparam logic [3:0] OFF_PORT_IN  = 4'h1;
    localparam logic [3:0] OFF_TLO      = 4'h2;
    localparam logic [3:0] OFF_THI      = 4'h3;
    localparam logic [3:0] OFF_CTRL     = 4'h4;
    localparam logic [3:0] OFF_STATUS   = 4'h5;
    localparam logic [3:0] OFF_SCRATCH  = 4'h6;

    // CTRL bits
    localparam int CTRL_TEN = 0;
    localparam int CTRL_ARL = 1;
    localparam int CTRL_TIE = 2;

    // STATUS bits
    localparam int STAT_TFLAG = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/io_timer16.sv
// io_timer16
//   16-bit down-timer with optional auto-reload and a sticky expiry flag.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     ten, arl      timer enable, auto-reload enable (from CTRL)
//     wr_lo         load the low-byte latch from wr_data
//     wr_hi         load cnt/reload with {wr_data, lo_latch} and start
//     rd_lo         a TLO read is committing: snapshot cnt[15:8]
//     clr_tflag     write-1-clear of tflag
//     wr_data       write data byte
//     cnt_lo        live cnt[7:0]
//     snap          high byte captured by the last TLO read
//     tflag         expiry flag
module io_timer16 (
    input  logic       clk,
    input  logic       reset,
    input  logic       ten,
    input  logic       arl,
    input  logic       wr_lo,
    input  logic       wr_hi,
    input  logic       rd_lo,
    input  logic       clr_tflag,
    input  logic [7:0] wr_data,
    output logic [7:0] cnt_lo,
    output logic [7:0] snap,
    output logic       tflag
);

    logic [15:0] cnt;
    logic [15:0] reload;
    logic [7:0]  lo_latch;
    logic        running;
    logic        expire;

    assign expire = ten && running && (cnt == 16'h0000);
    assign cnt_lo = cnt[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            reload   <= '0;
            lo_latch <= '0;
            running  <= 1'b0;
            snap     <= '0;
            tflag    <= 1'b0;
        end else begin
            if (wr_lo) lo_latch <= wr_data;
            // Snapshot the high byte so a following THI read pairs with
            // the low byte returned now.
            if (rd_lo) snap <= cnt[15:8];
            // A THI write takes priority over the reload of an expiry.
            if (wr_hi) begin
                cnt     <= {wr_data, lo_latch};
                reload  <= {wr_data, lo_latch};
                running <= 1'b1;
            end else if (ten && running) begin
                if (cnt == 16'h0000) begin
                    if (arl) cnt <= reload;
                    else     running <= 1'b0;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
            // Setting the flag beats a same-edge clear.
            if (expire)         tflag <= 1'b1;
            else if (clr_tflag) tflag <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_bus_io_responder.sv
// cpu_bus_io_responder
//   Memory-mapped I/O responder on the cpu65CE02 bus. Decodes a 16-byte
//   window at BASE_ADDR, holds output/input ports, a 16-bit timer,
//   CTRL/STATUS and a scratch register, stretches accesses with
//   WAIT_STATES ready-low cycles and drives irq/nmi.
//   Bus handshake: the CPU presents address_next/write_next/data_o_next
//   for the coming cycle; an access is sampled only in IDLE or DONE, and
//   while ready is low the CPU holds and the responder ignores the bus.
//   cs=1 marks the cycle in which rd_data owns the CPU data_i mux.
//   Ports:
//     clk, reset                        clock, async active-high reset
//     address_next/write_next/data_o_next  CPU next-cycle bus
//     rd_data, cs, ready                registered responses
//     port_in, port_out                 external pins
//     irq, nmi                          level interrupts to the CPU
//     dbg_state                         access FSM state
module cpu_bus_io_responder
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hBFF0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_o_next,
    output logic [7:0]  rd_data,
    output logic        cs,
    output logic        ready,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic        irq,
    output logic        nmi,
    output state_t      dbg_state
);

    localparam logic [2:0] WS_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t     state;
    logic [2:0] ws_cnt;
    logic [3:0] acc_off;
    logic       acc_we;
    logic [7:0] acc_wd;
    logic [7:0] acc_pin;

    logic [2:0] ctrl;
    logic [7:0] scratch;

    logic       sel_next;
    logic       commit;
    logic [3:0] c_off;
    logic       c_we;
    logic [7:0] c_wd;
    logic [7:0] c_pin;
    logic [7:0] rd_mux;

    logic [7:0] tmr_cnt_lo;
    logic [7:0] tmr_snap;
    logic       tflag;

    assign sel_next  = (address_next[15:4] == BASE_ADDR[15:4]);
    assign dbg_state = state;
    assign irq       = port_out[0] | (tflag & ctrl[CTRL_TIE]);
    assign nmi       = port_out[1];

    // With zero wait states the access commits straight from the bus on
    // its capture edge; otherwise it commits from the latched access regs.
    always_comb begin
        if (WAIT_STATES == 0) begin
            commit = ((state == ST_IDLE) || (state == ST_DONE)) && sel_next;
            c_off  = address_next[3:0];
            c_we   = write_next;
            c_wd   = data_o_next;
            c_pin  = port_in;
        end else begin
            commit = (state == ST_WAIT) && (ws_cnt == 3'd0);
            c_off  = acc_off;
            c_we   = acc_we;
            c_wd   = acc_wd;
            c_pin  = acc_pin;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (c_off)
            OFF_PORT_OUT: rd_mux = port_out;
            OFF_PORT_IN:  rd_mux = c_pin;
            OFF_TLO:      rd_mux = tmr_cnt_lo;
            OFF_THI:      rd_mux = tmr_snap;
            OFF_CTRL:     rd_mux = {5'b00000, ctrl};
            OFF_STATUS:   rd_mux = {irq, 6'b000000, tflag};
            OFF_SCRATCH:  rd_mux = scratch;
            default:      rd_mux = 8'h00;
        endcase
    end

    // Access FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            cs      <= 1'b0;
            rd_data <= 8'h00;
            ws_cnt  <= 3'd0;
            acc_off <= 4'h0;
            acc_we  <= 1'b0;
            acc_wd  <= 8'h00;
            acc_pin <= 8'h00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (sel_next) begin
                        acc_off <= address_next[3:0];
                        acc_we  <= write_next;
                        acc_wd  <= data_o_next;
                        acc_pin <= port_in;
                        if (WAIT_STATES == 0) begin
                            cs      <= 1'b1;
                            rd_data <= c_we ? 8'h00 : rd_mux;
                            state   <= ST_IDLE;
                        end else begin
                            cs     <= 1'b0;
                            ready  <= 1'b0;
                            ws_cnt <= WS_INIT;
                            state  <= ST_WAIT;
                        end
                    end else begin
                        cs    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ws_cnt == 3'd0) begin
                        rd_data <= c_we ? 8'h00 : rd_mux;
                        ready   <= 1'b1;
                        cs      <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        ws_cnt <= ws_cnt - 3'd1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    cs    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out <= 8'h00;
            ctrl     <= 3'b000;
            scratch  <= 8'h00;
        end else if (commit && c_we) begin
            case (c_off)
                OFF_PORT_OUT: port_out <= c_wd;
                OFF_CTRL:     ctrl     <= c_wd[2:0];
                OFF_SCRATCH:  scratch  <= c_wd;
                default: ;
            endcase
        end
    end

    io_timer16 u_timer (
        .clk       (clk),
        .reset     (reset),
        .ten       (ctrl[CTRL_TEN]),
        .arl       (ctrl[CTRL_ARL]),
        .wr_lo     (commit && c_we && (c_off == OFF_TLO)),
        .wr_hi     (commit && c_we && (c_off == OFF_THI)),
        .rd_lo     (commit && !c_we && (c_off == OFF_TLO)),
        .clr_tflag (commit && c_we && (c_off == OFF_STATUS) && c_wd[STAT_TFLAG]),
        .wr_data   (c_wd),
        .cnt_lo    (tmr_cnt_lo),
        .snap      (tmr_snap),
        .tflag     (tflag)
    );

endmodule
